// File: rtl/aes_enc_arbiter.sv
// Two-requester round-robin front end for a shared AES encoder core.
// Each grant produces exactly one response: ciphertext, or a zeroed timeout.
module aes_enc_arbiter #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [0:127] req0_text,
    input  logic [0:127] req1_text,
    input  logic [0:127] req0_key,
    input  logic [0:127] req1_key,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [0:127] rsp_data,
    output logic         rsp_id,
    output logic         rsp_timeout,
    output logic         enc_start,
    output logic [0:127] enc_plain_text,
    output logic [0:127] enc_key,
    input  logic [0:127] enc_data,
    input  logic         enc_valid,
    output logic         busy,
    output logic [15:0]  done_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_last_grant;
    logic          r_req_id;
    logic [0:127]  r_text;
    logic [0:127]  r_key;
    logic [0:127]  r_rsp_data;
    logic          r_rsp_timeout;
    logic [7:0]    r_wait_cnt;
    logic [15:0]   r_done_count;

    logic          w_grant_valid;
    logic          w_grant_id;
    logic          w_enc_hit;
    logic          w_timeout;
    logic          w_rsp_hs;
    logic [8:0]    w_wait_next;

    // Grants only exist in IDLE, so the RESP->IDLE cycle can never grant.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        if (r_state == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = ~r_last_grant;
            end else if (req0_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b0;
            end else if (req1_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b1;
            end
        end
    end

    assign req0_ready = w_grant_valid && !w_grant_id;
    assign req1_ready = w_grant_valid &&  w_grant_id;

    // Counter value after this WAIT cycle equals the number of WAIT cycles spent.
    assign w_wait_next = {1'b0, r_wait_cnt} + 9'd1;
    assign w_enc_hit   = (r_state == S_WAIT) && enc_valid;
    assign w_timeout   = (r_state == S_WAIT) && !enc_valid && (w_wait_next == 9'(TIMEOUT));
    assign w_rsp_hs    = (r_state == S_RESP) && rsp_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_valid) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_WAIT;
            S_WAIT:  if (w_enc_hit || w_timeout) w_state_next = S_RESP;
            S_RESP:  if (w_rsp_hs) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_last_grant  <= 1'b1;
            r_req_id      <= 1'b0;
            r_text        <= '0;
            r_key         <= '0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_wait_cnt    <= '0;
            r_done_count  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_valid) begin
                r_text       <= w_grant_id ? req1_text : req0_text;
                r_key        <= w_grant_id ? req1_key  : req0_key;
                r_req_id     <= w_grant_id;
                r_last_grant <= w_grant_id;
            end
            if (r_state == S_LOAD) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= w_wait_next[7:0];
            end
            if (w_enc_hit) begin
                r_rsp_data    <= enc_data;
                r_rsp_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_data    <= '0;
                r_rsp_timeout <= 1'b1;
            end
            if (w_rsp_hs) begin
                r_done_count <= r_done_count + 16'd1;
            end
        end
    end

    assign enc_start      = (r_state == S_LOAD);
    assign enc_plain_text = r_text;
    assign enc_key        = r_key;
    assign rsp_valid      = (r_state == S_RESP);
    assign rsp_data       = r_rsp_data;
    assign rsp_id         = r_req_id;
    assign rsp_timeout    = r_rsp_timeout;
    assign busy           = (r_state != S_IDLE);
    assign done_count     = r_done_count;

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// Directed bench for aes_enc_arbiter with a fixed-latency encoder model.
module tb_aes_enc_arbiter;

    localparam int unsigned TO = 15;

    localparam logic [0:127] TEXT0   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] KEY0    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] TEXT1   = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [0:127] KEY1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clock;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [0:127] req0_text, req1_text, req0_key, req1_key;
    logic         rsp_valid, rsp_ready;
    logic [0:127] rsp_data;
    logic         rsp_id, rsp_timeout;
    logic         enc_start;
    logic [0:127] enc_plain_text, enc_key, enc_data;
    logic         enc_valid;
    logic         busy;
    logic [15:0]  done_count;

    aes_enc_arbiter #(.TIMEOUT(TO)) u_dut (
        .clock          (clock),
        .reset          (reset),
        .req0_valid     (req0_valid),
        .req1_valid     (req1_valid),
        .req0_ready     (req0_ready),
        .req1_ready     (req1_ready),
        .req0_text      (req0_text),
        .req1_text      (req1_text),
        .req0_key       (req0_key),
        .req1_key       (req1_key),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_id         (rsp_id),
        .rsp_timeout    (rsp_timeout),
        .enc_start      (enc_start),
        .enc_plain_text (enc_plain_text),
        .enc_key        (enc_key),
        .enc_data       (enc_data),
        .enc_valid      (enc_valid),
        .busy           (busy),
        .done_count     (done_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         v0;
        logic         v1;
        int unsigned  dly;    // enc_valid this many cycles after enc_start; 0 = never
        logic [0:127] data;
        int unsigned  bp;     // extra cycles rsp_ready stays low
        logic         exp_id;
        logic         exp_to;
    } op_t;

    op_t         ops [8];
    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    int unsigned exp_done = 0;

    // Encoder model state: cycle index relative to the enc_start cycle.
    logic        m_active = 1'b0;
    int unsigned m_idx    = 0;
    int unsigned m_dly    = 0;
    int unsigned m_starts = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (enc_start) begin
            m_active = 1'b1;
            m_idx    = 0;
            m_starts++;
        end else if (m_active) begin
            m_idx++;
        end
        enc_valid = m_active && (m_dly != 0) && (m_idx == m_dly);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        m_active = 1'b0;
        tick();
        tick();
        reset    = 1'b0;
        exp_done = 0;
        #1;
    endtask

    task automatic run_op(input op_t v);
        int unsigned  cyc;
        int unsigned  viol;
        int unsigned  exp_lat;
        logic         got;
        logic [0:127] exp_text, exp_key, s_data;
        logic         s_id, s_to;

        req0_valid = v.v0;
        req1_valid = v.v1;
        m_dly      = v.dly;
        enc_data   = v.data;
        #1;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 20) begin
            if (req0_ready || req1_ready) got = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        if (!got) begin
            chk("grant_wait", 128'(0), 128'(1));
            return;
        end
        chk("grant", 128'({req1_ready, req0_ready}), v.exp_id ? 128'(2) : 128'(1));

        m_starts = 0;
        tick();
        exp_text = v.exp_id ? TEXT1 : TEXT0;
        exp_key  = v.exp_id ? KEY1  : KEY0;
        chk("enc_start_load", 128'(enc_start), 128'(1));
        chk("enc_plain_text", enc_plain_text, exp_text);
        chk("enc_key", enc_key, exp_key);

        cyc  = 0;
        viol = 0;
        while (!rsp_valid && cyc < 40) begin
            if (req0_ready || req1_ready || !busy) viol++;
            if (enc_plain_text !== exp_text || enc_key !== exp_key) viol++;
            tick();
            cyc++;
        end
        exp_lat = v.exp_to ? TO + 1 : v.dly + 1;
        chk("latency", 128'(cyc), 128'(exp_lat));
        chk("rsp_data", rsp_data, v.exp_to ? '0 : v.data);
        chk("rsp_id", 128'(rsp_id), 128'(v.exp_id));
        chk("rsp_timeout", 128'(rsp_timeout), 128'(v.exp_to));

        s_data = rsp_data;
        s_id   = rsp_id;
        s_to   = rsp_timeout;
        for (int i = 0; i < int'(v.bp); i++) begin
            tick();
            if (!rsp_valid || rsp_data !== s_data || rsp_id !== s_id || rsp_timeout !== s_to) viol++;
            if (req0_ready || req1_ready || enc_start) viol++;
        end
        rsp_ready = 1'b1;
        #1;
        if (req0_ready || req1_ready) viol++;
        tick();
        rsp_ready = 1'b0;
        exp_done++;
        chk("hold_violations", 128'(viol), 128'(0));
        chk("rsp_valid_cleared", 128'(rsp_valid), 128'(0));
        chk("enc_start_count", 128'(m_starts), 128'(1));
        chk("done_count", 128'(done_count), 128'(16'(exp_done)));
    endtask

    initial begin
        int unsigned viol;
        int unsigned waited;

        reset      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_text  = TEXT0;
        req0_key   = KEY0;
        req1_text  = TEXT1;
        req1_key   = KEY1;
        rsp_ready  = 1'b0;
        enc_data   = '0;
        enc_valid  = 1'b0;

        ops[0] = '{1'b1, 1'b1, 12, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 0, 1'b0, 1'b0};
        ops[1] = '{1'b1, 1'b1,  9, 128'h11111111222222223333333344444444, 0, 1'b1, 1'b0};
        ops[2] = '{1'b1, 1'b1,  3, 128'hcafef00dcafef00dcafef00dcafef00d, 5, 1'b0, 1'b0};
        ops[3] = '{1'b1, 1'b1,  1, 128'h0123456789abcdef0123456789abcdef, 0, 1'b1, 1'b0};
        ops[4] = '{1'b0, 1'b1,  5, 128'ha5a5a5a55a5a5a5aa5a5a5a55a5a5a5a, 0, 1'b1, 1'b0};
        ops[5] = '{1'b1, 1'b0, 15, 128'hfedcba9876543210fedcba9876543210, 0, 1'b0, 1'b0};
        ops[6] = '{1'b1, 1'b1,  0, 128'hffffffffffffffffffffffffffffffff, 2, 1'b1, 1'b1};
        ops[7] = '{1'b1, 1'b1, 14, 128'h13579bdf02468ace13579bdf02468ace, 0, 1'b0, 1'b0};

        do_reset();
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("reset_rsp_data", rsp_data, '0);
        chk("reset_rsp_id", 128'(rsp_id), 128'(0));
        chk("reset_rsp_timeout", 128'(rsp_timeout), 128'(0));
        chk("reset_enc_start", 128'(enc_start), 128'(0));
        chk("reset_enc_text", enc_plain_text, '0);
        chk("reset_enc_key", enc_key, '0);
        chk("reset_done_count", 128'(done_count), 128'(0));

        run_op('{1'b1, 1'b0, 12, FIPS_CT, 0, 1'b0, 1'b0});
        req0_valid = 1'b0;

        do_reset();
        chk("reset2_done_count", 128'(done_count), 128'(0));
        foreach (ops[i]) run_op(ops[i]);

        // Reset mid-WAIT, then the abandoned encoder job answers late.
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        m_dly      = 6;
        #1;
        waited = 0;
        while (!req0_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk("stale_grant", 128'(req0_ready), 128'(1));
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("stale_in_wait", 128'(busy), 128'(1));
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        exp_done = 0;
        viol     = 0;
        waited   = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid || busy) viol++;
            if (enc_valid) waited++;
            tick();
        end
        chk("stale_seen_by_model", 128'(waited), 128'(1));
        chk("stale_ignored", 128'(viol), 128'(0));
        chk("stale_done_count", 128'(done_count), 128'(0));
        chk("stale_busy", 128'(busy), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_enc_arbiter.md
AES_ENC_ARBITER -- requirements
Module: aes_enc_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 63, meaning the maximum number of WAIT cycles before an operation is aborted (legal range 15..255).
REQ-002 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 each, meaning requester N offers a block.
REQ-005 SHALL have ports req0_ready and req1_ready, output, 1 each, meaning requester N is accepted this cycle.
REQ-006 SHALL have ports req0_text and req1_text, input, [0:127] each, the plaintext.
REQ-007 SHALL have ports req0_key and req1_key, input, [0:127] each, the cipher key.
REQ-008 SHALL have port rsp_valid, output, 1, meaning a response is pending.
REQ-009 SHALL have port rsp_ready, input, 1, meaning the consumer takes the response.
REQ-010 SHALL have port rsp_data, output, [0:127], the ciphertext.
REQ-011 SHALL have port rsp_id, output, 1, the index of the requester that owns the response.
REQ-012 SHALL have port rsp_timeout, output, 1, meaning the operation was aborted.
REQ-013 SHALL have ports enc_start, output, 1; enc_plain_text, output, [0:127]; and enc_key, output, [0:127], all driving the shared encoder.
REQ-014 SHALL have ports enc_data, input, [0:127], and enc_valid, input, 1, both returned by the encoder.
REQ-015 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-016 SHALL have port done_count, output, 16, counting completed responses.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD, WAIT and RESP.
REQ-018 SHALL, in IDLE, assert at most one reqN_ready combinationally, and only when the corresponding reqN_valid is high.
REQ-019 SHALL arbitrate round-robin: when both requesters are valid, grant the one not equal to last_grant; when only one is valid, grant it.
REQ-020 SHALL treat a handshake as valid && ready; on a handshake it SHALL register text, key and the requester id, update last_grant, and transition IDLE -> LOAD.
REQ-021 SHALL hold reqN_ready low in LOAD, WAIT and RESP.
REQ-022 SHALL assert enc_start for exactly one cycle, in LOAD; LOAD -> WAIT unconditionally.
REQ-023 SHALL drive enc_plain_text and enc_key from the registered values and hold them stable from LOAD until leaving WAIT, because the encoder reads the key every round.
REQ-024 SHALL ignore enc_valid in every state except WAIT, including the LOAD cycle.
REQ-025 SHALL clear the WAIT cycle counter on entry to WAIT and increment it each WAIT cycle.
REQ-026 SHALL, when enc_valid is high in WAIT, register enc_data into rsp_data, set rsp_timeout=0, and transition WAIT -> RESP.
REQ-027 SHALL, when the WAIT counter reaches TIMEOUT without enc_valid, set rsp_data=0 and rsp_timeout=1, and transition WAIT -> RESP.
REQ-028 SHALL give enc_valid priority over timeout when both occur in the same cycle.
REQ-029 SHALL assert rsp_valid only in RESP, with rsp_data, rsp_id and rsp_timeout held stable while rsp_valid && !rsp_ready.
REQ-030 SHALL, on rsp_valid && rsp_ready, increment done_count (wrapping 0xFFFF -> 0x0000, timeouts included) and transition RESP -> IDLE.
REQ-031 SHALL make no new grant in the same cycle as the RESP -> IDLE transition.
REQ-032 SHALL meet this latency: handshake in cycle T, enc_start in T+1, WAIT from T+2, rsp_valid in the cycle after enc_valid is sampled.

Reset
REQ-033 SHALL, on reset, force state=IDLE, last_grant=1 (so requester 0 wins the first tie), and done_count=0.
REQ-034 SHALL, on reset, force rsp_valid=0, rsp_data=0, rsp_id=0, rsp_timeout=0, enc_start=0, enc_plain_text=0, enc_key=0, the WAIT counter=0 and busy=0.
REQ-035 SHALL, on reset mid-operation in any state, abandon the in-flight block without issuing a response and ignore any later enc_valid until the next LOAD.

Verification
REQ-036 SHALL cover single request: req0 with FIPS-197 text 00112233445566778899aabbccddeeff and key 000102030405060708090a0b0c0d0e0f, with the encoder model returning 69c4e0d86a7b0430d8cdb78070b4c55a after 12 cycles -> rsp_valid with that data, rsp_id=0, rsp_timeout=0, done_count=1.
REQ-037 SHALL cover a simultaneous request: both valid after reset -> req0 granted first, req1 granted on the next IDLE, with rsp_id sequence 0,1.
REQ-038 SHALL cover back-to-back: both valid continuously for 4 operations -> grant order 0,1,0,1 and exactly one enc_start per operation.
REQ-039 SHALL cover timeout: TIMEOUT=15 with enc_valid never asserted -> rsp_valid with rsp_timeout=1, rsp_data=0, done_count incremented.
REQ-040 SHALL cover backpressure: rsp_ready held low 5 cycles -> rsp fields stable, reqN_ready low, and no enc_start until acceptance.
REQ-041 SHALL cover reset in WAIT followed by a stale enc_valid -> no rsp_valid, state IDLE, and done_count=0.
